digit_serial_adder: RTL
=======================

# digit_serial_adder

Parametrised, multi-cycle add/subtract unit. It generalises the team's 16-bit ripple-carry adder to any WIDTH and processes DIGIT bits per clock, LSB digit first, under a start/busy/done handshake. The block sits beside the datapath where area matters more than single-cycle latency. It shares one DIGIT-wide carry-chain slice across all digits.

## Interface
- WIDTH, 16: operand/result width in bits. Must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle. NDIG = WIDTH/DIGIT. DIGIT == WIDTH is legal (single-digit mode).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE, or in the DONE cycle.
- sub  input  1  0 = a+b+car_in; 1 = a+~b+(~car_in), i.e. a−b−car_in (car_in acts as borrow).
- car_in  input  1  carry/borrow in; sampled with start.
- a, b  input  WIDTH  operands; sampled with start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when sum/car_out are updated.
- sum  output  WIDTH  registered result; holds until the next completion.
- car_out  output  1  raw carry out of the MSB. In sub mode, 1 = no borrow.
- ovf  output  1  signed overflow. Present only with DIGIT_SERIAL_ADDER_OVF_EN.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1, digit counter k = 0..NDIG−1.
  - DONE: one cycle, done=1, busy=0.
- IDLE/DONE + start=1: latch a into the A shift register, and b ^ {WIDTH{sub}} into the B shift register. Set carry = car_in ^ sub, k = 0, and go to RUN.
- RUN, each cycle:
  - {c, s} = A[DIGIT−1:0] + B[DIGIT−1:0] + carry.
  - Shift s into the top of the partial-sum register; shift A and B right by DIGIT.
  - carry ← c; k ← k+1.
- RUN with k == NDIG−1: the final digit is computed that cycle. At that edge:
  - sum ← completed partial sum; car_out ← final c; ovf ← c_into_msb ^ c_out_msb.
  - Go to DONE.
- DONE with start=0: go to IDLE.
- start while busy: ignored; no queueing.
- sum, car_out and ovf change only on the edge that enters DONE. They are stable at all other times.
- All arithmetic is unsigned modulo 2^WIDTH. car_out is the (WIDTH+1)th bit.
- The signed-overflow term uses the carry into bit WIDTH−1. This is taken from inside the final digit's adder.

## Timing
- Reset (async assert, sync release):
  - State IDLE, busy=0, done=0, sum=0, car_out=0, ovf=0.
  - Internal registers are cleared.
- Latency: start sampled at edge T0. busy is high after T0 for NDIG cycles. The result and done=1 appear after edge T0+NDIG; done is high for exactly one cycle.
- Throughput: one result per NDIG+1 cycles. A start asserted during the DONE cycle is accepted, so a new RUN begins at the next edge.
- NDIG == 1: RUN lasts one cycle; done follows one edge after start.
- Reset asserted mid-RUN: the operation is aborted immediately. There is no done pulse, and all outputs return to their reset values.
- Operand inputs may change freely after the start edge.

## Configuration
- DIGIT_SERIAL_ADDER_OVF_EN defined:
  - ovf port exists; it is registered and updated with sum.
  - ovf = 1 when the signed interpretation of the result overflows, for both add and sub.
- Not defined: the ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=16, DIGIT=4, start with a=0x1234, b=0x4321, car_in=0, sub=0:
  - busy for 4 cycles, then done pulse.
  - sum=0x5555, car_out=0.
- a=0xFFFF, b=0x0001, car_in=0, sub=0 -> sum=0x0000, car_out=1, ovf=0.
  - a=0x7FFF, b=0x0001 -> sum=0x8000, car_out=0, ovf=1.
- sub=1, a=0x0005, b=0x0007, car_in=0 -> sum=0xFFFE, car_out=0, ovf=0.
  - a=0x8000, b=0x0001 -> sum=0x7FFF, car_out=1, ovf=1.
- Pulse start again 2 cycles into RUN with different operands:
  - The second request is ignored; the first result completes unchanged.
  - Then assert start in the DONE cycle: it is accepted, and the second done arrives 5 cycles after the first.
- Assert rst_n=0 mid-RUN:
  - All outputs go to 0 asynchronously, with no done pulse.
  - After release, a fresh add (0x0001+0x0001) gives sum=0x0002.
- WIDTH=16, DIGIT=16: 0x1234+0x4321 -> done one cycle after start, sum=0x5555.
  - WIDTH=8, DIGIT=2: 0xFF+0x01+car_in=1 -> sum=0x01, car_out=1, after 4 busy cycles.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract unit: one DIGIT-wide carry slice, LSB digit first, start/busy/done handshake.
// Define DIGIT_SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             car_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             car_out
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,output logic            ovf
`endif
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             carOut_q, carOut_d;
    logic [KW-1:0]    k_q, k_d;

    logic [DIGIT:0]         digitSum;
    logic                   msbCarryIn;
    logic [WIDTH+DIGIT-1:0] psumShift;
    logic                   lastDigit;
    logic                   accept;

    assign digitSum   = {1'b0, aSh_q[DIGIT-1:0]} + {1'b0, bSh_q[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, carry_q};
    // Carry into the digit's top bit recovered from its sum bit and operand bits.
    assign msbCarryIn = digitSum[DIGIT-1] ^ aSh_q[DIGIT-1] ^ bSh_q[DIGIT-1];
    assign psumShift  = {digitSum[DIGIT-1:0], psum_q};
    assign lastDigit  = (k_q == KW'(NDIG - 1));
    assign accept     = start && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (lastDigit) state_d = DONE;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_comb begin
        aSh_d    = aSh_q;
        bSh_d    = bSh_q;
        psum_d   = psum_q;
        carry_d  = carry_q;
        k_d      = k_q;
        sum_d    = sum_q;
        carOut_d = carOut_q;
        if (accept) begin
            aSh_d   = a;
            bSh_d   = b ^ {WIDTH{sub}};
            carry_d = car_in ^ sub;
            k_d     = '0;
        end else if (state_q == RUN) begin
            aSh_d   = aSh_q >> DIGIT;
            bSh_d   = bSh_q >> DIGIT;
            psum_d  = psumShift[WIDTH+DIGIT-1:DIGIT];
            carry_d = digitSum[DIGIT];
            k_d     = k_q + KW'(1);
            if (lastDigit) begin
                sum_d    = psumShift[WIDTH+DIGIT-1:DIGIT];
                carOut_d = digitSum[DIGIT];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aSh_q    <= '0;
            bSh_q    <= '0;
            psum_q   <= '0;
            carry_q  <= 1'b0;
            k_q      <= '0;
            sum_q    <= '0;
            carOut_q <= 1'b0;
        end else begin
            aSh_q    <= aSh_d;
            bSh_q    <= bSh_d;
            psum_q   <= psum_d;
            carry_q  <= carry_d;
            k_q      <= k_d;
            sum_q    <= sum_d;
            carOut_q <= carOut_d;
        end
    end

    assign sum     = sum_q;
    assign car_out = carOut_q;

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && lastDigit && !accept) begin
            ovf_q <= msbCarryIn ^ digitSum[DIGIT];
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
